// File: rtl/alu_issue_sched_pkg.sv
// Shared types for the ALU reservation-station scheduler: operand/entry records
// and the CDB wakeup helper used by both stored entries and the dispatch bypass.
package alu_issue_sched_pkg;

  localparam int ROB_DEPTH_DEF = 4;
  localparam int TAG_W = $clog2(ROB_DEPTH_DEF);

  typedef struct packed {
    logic             rdy;
    logic [TAG_W-1:0] tag;
    logic [31:0]      v;
  } rs_operand_t;

  typedef struct packed {
    logic             valid;
    logic [31:0]      instr;
    logic [TAG_W-1:0] rob_tag;
    rs_operand_t      rs1;
    rs_operand_t      rs2;
  } rs_entry_t;

  // A pending operand whose producer tag is on the CDB takes the broadcast value.
  function automatic rs_operand_t wake_operand(input rs_operand_t op,
                                               input logic cdb_valid,
                                               input logic [TAG_W-1:0] cdb_tag,
                                               input logic [31:0] cdb_value);
    rs_operand_t r;
    r = op;
    if (!op.rdy && cdb_valid && (op.tag == cdb_tag)) begin
      r.rdy = 1'b1;
      r.v   = cdb_value;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_issue_sched_if.sv
// Dispatch, CDB snoop, ALU issue/response and CDB result bundle of the ALU scheduler.
// The slave side is the scheduler; the master side is the surrounding core.
interface alu_issue_sched_if #(parameter int TW = 2);

  logic          disp_valid;
  logic          disp_ready;
  logic [31:0]   disp_instr;
  logic [TW-1:0] disp_rob_tag;
  logic          disp_rs1_rdy;
  logic          disp_rs2_rdy;
  logic [31:0]   disp_rs1_v;
  logic [31:0]   disp_rs2_v;
  logic [TW-1:0] disp_rs1_tag;
  logic [TW-1:0] disp_rs2_tag;

  logic          cdb_in_valid;
  logic [TW-1:0] cdb_in_tag;
  logic [31:0]   cdb_in_value;

  logic          alu_en;
  logic [31:0]   alu_instr;
  logic [31:0]   alu_rs1_v;
  logic [31:0]   alu_rs2_v;
  logic [TW-1:0] alu_rob_tag;
  logic          alu_resp;
  logic [31:0]   alu_result;

  logic          cdb_req;
  logic          cdb_gnt;
  logic [TW-1:0] cdb_out_tag;
  logic [31:0]   cdb_out_value;
  logic          illegal_op;

  modport master (
    output disp_valid, disp_instr, disp_rob_tag, disp_rs1_rdy, disp_rs2_rdy,
           disp_rs1_v, disp_rs2_v, disp_rs1_tag, disp_rs2_tag,
           cdb_in_valid, cdb_in_tag, cdb_in_value, alu_resp, alu_result, cdb_gnt,
    input  disp_ready, alu_en, alu_instr, alu_rs1_v, alu_rs2_v, alu_rob_tag,
           cdb_req, cdb_out_tag, cdb_out_value, illegal_op
  );

  modport slave (
    input  disp_valid, disp_instr, disp_rob_tag, disp_rs1_rdy, disp_rs2_rdy,
           disp_rs1_v, disp_rs2_v, disp_rs1_tag, disp_rs2_tag,
           cdb_in_valid, cdb_in_tag, cdb_in_value, alu_resp, alu_result, cdb_gnt,
    output disp_ready, alu_en, alu_instr, alu_rs1_v, alu_rs2_v, alu_rob_tag,
           cdb_req, cdb_out_tag, cdb_out_value, illegal_op
  );

endinterface

// File: rtl/alu_issue_sched_age_select.sv
// Age matrix over the reservation-station slots plus a one-hot select of the
// oldest ready slot. older_q[i][j] set means slot i was dispatched before slot j.
module rs_age_select #(
  parameter int RS_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                alloc_en,
  input  logic [RS_DEPTH-1:0] alloc_oh,
  input  logic [RS_DEPTH-1:0] valid_vec,
  input  logic [RS_DEPTH-1:0] ready_vec,
  output logic [RS_DEPTH-1:0] grant_oh
);

  logic [RS_DEPTH-1:0] older_q [RS_DEPTH];

  // A new slot is younger than every slot valid at dispatch; stale rows of freed
  // slots are harmless because select only looks at ready (hence valid) slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RS_DEPTH; i++) older_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < RS_DEPTH; i++) older_q[i] <= '0;
    end else if (alloc_en) begin
      for (int k = 0; k < RS_DEPTH; k++) begin
        if (alloc_oh[k]) begin
          for (int j = 0; j < RS_DEPTH; j++) begin
            older_q[k][j] <= 1'b0;
            older_q[j][k] <= valid_vec[j] && (j != k);
          end
        end
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      grant_oh[i] = ready_vec[i];
      for (int j = 0; j < RS_DEPTH; j++) begin
        if ((j != i) && ready_vec[j] && older_q[j][i]) grant_oh[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_issue_sched.sv
// Integer-ALU reservation station: dispatch into free slots, CDB wakeup,
// oldest-ready issue to the external ALU, one-deep result register toward the CDB.
module alu_issue_sched
  import alu_issue_sched_pkg::*;
#(
  parameter int RS_DEPTH  = 4,
  parameter int ROB_DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  input logic flush,
  alu_issue_sched_if.slave bus
);

  localparam int TW = $clog2(ROB_DEPTH);

  rs_entry_t           rs_q [RS_DEPTH];
  logic [RS_DEPTH-1:0] valid_vec;
  logic [RS_DEPTH-1:0] ready_vec;
  logic [RS_DEPTH-1:0] alloc_oh;
  logic [RS_DEPTH-1:0] grant_oh;
  logic [RS_DEPTH-1:0] issue_oh;
  logic                disp_fire;
  logic                issue_any;
  rs_operand_t         disp_rs1;
  rs_operand_t         disp_rs2;

  logic [31:0]         sel_instr;
  logic [TW-1:0]       sel_tag;
  logic [31:0]         sel_rs1_v;
  logic [31:0]         sel_rs2_v;

  logic                out_valid_q;
  logic [TW-1:0]       out_tag_q;
  logic [31:0]         out_value_q;
  logic                illegal_q;

  always_comb begin
    valid_vec = '0;
    ready_vec = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      valid_vec[i] = rs_q[i].valid;
      ready_vec[i] = rs_q[i].valid && rs_q[i].rs1.rdy && rs_q[i].rs2.rdy;
    end
  end

  // Lowest clear bit of the pre-issue valid vector, so a slot freed this cycle
  // is never reused in the same cycle.
  assign alloc_oh       = ~valid_vec & (valid_vec + {{(RS_DEPTH-1){1'b0}}, 1'b1});
  assign bus.disp_ready = ~&valid_vec;
  assign disp_fire      = bus.disp_valid && bus.disp_ready;

  always_comb begin
    disp_rs1 = wake_operand(rs_operand_t'{bus.disp_rs1_rdy, bus.disp_rs1_tag, bus.disp_rs1_v},
                            bus.cdb_in_valid, bus.cdb_in_tag, bus.cdb_in_value);
    disp_rs2 = wake_operand(rs_operand_t'{bus.disp_rs2_rdy, bus.disp_rs2_tag, bus.disp_rs2_v},
                            bus.cdb_in_valid, bus.cdb_in_tag, bus.cdb_in_value);
  end

  rs_age_select #(.RS_DEPTH(RS_DEPTH)) u_age_select (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .alloc_en  (disp_fire),
    .alloc_oh  (alloc_oh),
    .valid_vec (valid_vec),
    .ready_vec (ready_vec),
    .grant_oh  (grant_oh)
  );

  assign issue_any = (!out_valid_q || bus.cdb_gnt) && (|ready_vec);
  assign issue_oh  = issue_any ? grant_oh : '0;

  always_comb begin
    sel_instr = '0;
    sel_tag   = '0;
    sel_rs1_v = '0;
    sel_rs2_v = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (issue_oh[i]) begin
        sel_instr = rs_q[i].instr;
        sel_tag   = rs_q[i].rob_tag;
        sel_rs1_v = rs_q[i].rs1.v;
        sel_rs2_v = rs_q[i].rs2.v;
      end
    end
  end

  assign bus.alu_en      = issue_any;
  assign bus.alu_instr   = sel_instr;
  assign bus.alu_rob_tag = sel_tag;
  assign bus.alu_rs1_v   = sel_rs1_v;
  assign bus.alu_rs2_v   = sel_rs2_v;

  // The allocated slot is free before the edge, so it can never also be the issued one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RS_DEPTH; i++) rs_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < RS_DEPTH; i++) rs_q[i] <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (disp_fire && alloc_oh[i]) begin
          rs_q[i] <= '{valid: 1'b1, instr: bus.disp_instr, rob_tag: bus.disp_rob_tag,
                       rs1: disp_rs1, rs2: disp_rs2};
        end else if (issue_oh[i]) begin
          rs_q[i].valid <= 1'b0;
        end else if (rs_q[i].valid) begin
          rs_q[i].rs1 <= wake_operand(rs_q[i].rs1, bus.cdb_in_valid, bus.cdb_in_tag, bus.cdb_in_value);
          rs_q[i].rs2 <= wake_operand(rs_q[i].rs2, bus.cdb_in_valid, bus.cdb_in_tag, bus.cdb_in_value);
        end
      end
    end
  end

  // Result register: a fresh ALU result wins over a same-cycle grant drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_value_q <= '0;
      illegal_q   <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      illegal_q <= issue_any && !bus.alu_resp;
      if (issue_any && bus.alu_resp) begin
        out_valid_q <= 1'b1;
        out_tag_q   <= sel_tag;
        out_value_q <= bus.alu_result;
      end else if (bus.cdb_gnt) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.cdb_req       = out_valid_q;
  assign bus.cdb_out_tag   = out_valid_q ? out_tag_q : '0;
  assign bus.cdb_out_value = out_valid_q ? out_value_q : '0;
  assign bus.illegal_op    = illegal_q;

endmodule

// File: tb/tb_alu_issue_sched.sv
// Directed bench for alu_issue_sched: expected issues and CDB results are queued
// with the stimulus and popped by a monitor whenever the DUT issues or broadcasts.
module tb_alu_issue_sched;

  localparam int TW = 2;
  localparam logic [31:0] ADDI_I = {12'd3, 5'd1, 3'b000, 5'd2, 7'b0010011};
  localparam logic [31:0] ADD_I  = {7'd0, 5'd3, 5'd1, 3'b000, 5'd2, 7'b0110011};
  localparam logic [31:0] BAD_I  = 32'h0000_0000;

  typedef struct {
    logic [TW-1:0] tag;
    logic [31:0]   a;
    logic [31:0]   b;
  } issue_exp_t;

  typedef struct {
    logic [TW-1:0] tag;
    logic [31:0]   value;
  } cdb_exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  issue_exp_t iss_q[$];
  cdb_exp_t   cdb_q[$];
  issue_exp_t iss_e;
  cdb_exp_t   cdb_e;

  alu_issue_sched_if #(.TW(TW)) bus();

  alu_issue_sched #(.RS_DEPTH(4), .ROB_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ALU stand-in: ADDI and ADD both add the two operand values; anything else is unsupported.
  always_comb begin
    bus.alu_resp   = 1'b0;
    bus.alu_result = '0;
    if (bus.alu_en && (bus.alu_instr[14:12] == 3'b000) &&
        ((bus.alu_instr[6:0] == 7'b0010011) ||
         ((bus.alu_instr[6:0] == 7'b0110011) && (bus.alu_instr[31:25] == 7'd0)))) begin
      bus.alu_resp   = 1'b1;
      bus.alu_result = bus.alu_rs1_v + bus.alu_rs2_v;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic apply_stimulus(input logic [31:0] instr, input logic [TW-1:0] tag,
                                input logic r1_rdy, input logic [TW-1:0] r1_tag,
                                input logic [31:0] r1_v, input logic r2_rdy,
                                input logic [31:0] r2_v);
    bus.disp_valid   = 1'b1;
    bus.disp_instr   = instr;
    bus.disp_rob_tag = tag;
    bus.disp_rs1_rdy = r1_rdy;
    bus.disp_rs1_tag = r1_tag;
    bus.disp_rs1_v   = r1_v;
    bus.disp_rs2_rdy = r2_rdy;
    bus.disp_rs2_tag = '0;
    bus.disp_rs2_v   = r2_v;
  endtask

  task automatic set_cdb(input logic valid, input logic [TW-1:0] tag, input logic [31:0] value);
    bus.cdb_in_valid = valid;
    bus.cdb_in_tag   = tag;
    bus.cdb_in_value = value;
  endtask

  task automatic idle();
    bus.disp_valid = 1'b0;
    set_cdb(1'b0, '0, '0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [TW-1:0] tag, input logic [31:0] a, input logic [31:0] b,
                          input logic with_cdb);
    iss_q.push_back('{tag: tag, a: a, b: b});
    if (with_cdb) cdb_q.push_back('{tag: tag, value: a + b});
  endtask

  // Monitor: every issue and every granted broadcast must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.alu_en) begin
        if (iss_q.size() == 0) begin
          check_output("issue_unexpected", {31'd0, bus.alu_en}, 32'd0);
        end else begin
          iss_e = iss_q.pop_front();
          check_output("issue_tag", {30'd0, bus.alu_rob_tag}, {30'd0, iss_e.tag});
          check_output("issue_rs1", bus.alu_rs1_v, iss_e.a);
          check_output("issue_rs2", bus.alu_rs2_v, iss_e.b);
        end
      end
      if (bus.cdb_req && bus.cdb_gnt) begin
        if (cdb_q.size() == 0) begin
          check_output("cdb_unexpected", {31'd0, bus.cdb_req}, 32'd0);
        end else begin
          cdb_e = cdb_q.pop_front();
          check_output("cdb_tag", {30'd0, bus.cdb_out_tag}, {30'd0, cdb_e.tag});
          check_output("cdb_value", bus.cdb_out_value, cdb_e.value);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.disp_valid = 1'b0;
    bus.disp_instr = '0;
    bus.disp_rob_tag = '0;
    bus.disp_rs1_rdy = 1'b0;
    bus.disp_rs2_rdy = 1'b0;
    bus.disp_rs1_v = '0;
    bus.disp_rs2_v = '0;
    bus.disp_rs1_tag = '0;
    bus.disp_rs2_tag = '0;
    bus.cdb_gnt = 1'b0;
    set_cdb(1'b0, '0, '0);

    // Reset state
    repeat (2) @(negedge clk);
    check_output("rst_disp_ready", {31'd0, bus.disp_ready}, 32'd1);
    check_output("rst_alu_en", {31'd0, bus.alu_en}, 32'd0);
    check_output("rst_cdb_req", {31'd0, bus.cdb_req}, 32'd0);
    check_output("rst_illegal", {31'd0, bus.illegal_op}, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Single ADDI: issue next cycle, broadcast the cycle after, then empty
    bus.cdb_gnt = 1'b1;
    apply_stimulus(ADDI_I, 2'd1, 1'b1, 2'd0, 32'd5, 1'b1, 32'd3);
    push_exp(2'd1, 32'd5, 32'd3, 1'b1);
    @(negedge clk) check_output("t1_no_issue_on_dispatch", {31'd0, bus.alu_en}, 32'd0);
    next_cycle(); idle();
    @(negedge clk) check_output("t1_issue", {31'd0, bus.alu_en}, 32'd1);
    next_cycle();
    @(negedge clk) check_output("t1_cdb_req", {31'd0, bus.cdb_req}, 32'd1);
    next_cycle();
    @(negedge clk) check_output("t1_cdb_req_drop", {31'd0, bus.cdb_req}, 32'd0);
    next_cycle();

    // Wakeup: rs1 waits on tag 3, broadcast two cycles after dispatch
    apply_stimulus(ADD_I, 2'd2, 1'b0, 2'd3, 32'd0, 1'b1, 32'h20);
    push_exp(2'd2, 32'h10, 32'h20, 1'b1);
    @(negedge clk);
    next_cycle(); idle();
    @(negedge clk) check_output("t2_wait", {31'd0, bus.alu_en}, 32'd0);
    next_cycle(); set_cdb(1'b1, 2'd3, 32'h10);
    @(negedge clk) check_output("t2_no_same_cycle_issue", {31'd0, bus.alu_en}, 32'd0);
    next_cycle(); idle();
    @(negedge clk) check_output("t2_issue_after_wake", {31'd0, bus.alu_en}, 32'd1);
    next_cycle();
    @(negedge clk);
    next_cycle();

    // Same-cycle dispatch and CDB match
    apply_stimulus(ADD_I, 2'd3, 1'b0, 2'd2, 32'd0, 1'b1, 32'd4);
    set_cdb(1'b1, 2'd2, 32'd7);
    push_exp(2'd3, 32'd7, 32'd4, 1'b1);
    @(negedge clk) check_output("t5_no_issue_on_dispatch", {31'd0, bus.alu_en}, 32'd0);
    next_cycle(); idle();
    @(negedge clk) check_output("t5_issue", {31'd0, bus.alu_en}, 32'd1);
    next_cycle();
    @(negedge clk);
    next_cycle();

    // Age order with the result register held: tag 0, then 1 (slot 1), then 2 (slot 0)
    bus.cdb_gnt = 1'b0;
    apply_stimulus(ADDI_I, 2'd0, 1'b1, 2'd0, 32'd10, 1'b1, 32'd1);
    push_exp(2'd0, 32'd10, 32'd1, 1'b1);
    @(negedge clk);
    next_cycle();
    apply_stimulus(ADDI_I, 2'd1, 1'b1, 2'd0, 32'd20, 1'b1, 32'd2);
    push_exp(2'd1, 32'd20, 32'd2, 1'b1);
    @(negedge clk) check_output("t3_first_issue", {31'd0, bus.alu_en}, 32'd1);
    next_cycle();
    apply_stimulus(ADDI_I, 2'd2, 1'b1, 2'd0, 32'd30, 1'b1, 32'd3);
    push_exp(2'd2, 32'd30, 32'd3, 1'b1);
    @(negedge clk) check_output("t3_blocked", {31'd0, bus.alu_en}, 32'd0);
    check_output("t3_held_value", bus.cdb_out_value, 32'd11);
    next_cycle(); idle();
    @(negedge clk) check_output("t3_still_blocked", {31'd0, bus.alu_en}, 32'd0);
    check_output("t3_held_req", {31'd0, bus.cdb_req}, 32'd1);
    next_cycle();
    bus.cdb_gnt = 1'b1;
    repeat (4) begin
      @(negedge clk);
      next_cycle();
    end

    // Full: four ops waiting on tags 0..3, fifth dispatch ignored
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(ADDI_I, TW'(k), 1'b0, TW'(k), 32'd0, 1'b1, 32'(k));
      next_cycle();
    end
    apply_stimulus(ADDI_I, 2'd0, 1'b1, 2'd0, 32'd50, 1'b1, 32'd1);
    @(negedge clk) check_output("t4_full", {31'd0, bus.disp_ready}, 32'd0);
    next_cycle(); idle(); set_cdb(1'b1, 2'd2, 32'd100);
    push_exp(2'd2, 32'd100, 32'd2, 1'b1);
    @(negedge clk) check_output("t4_fifth_ignored", {31'd0, bus.alu_en}, 32'd0);
    next_cycle(); idle();
    @(negedge clk) check_output("t4_full_during_issue", {31'd0, bus.disp_ready}, 32'd0);
    next_cycle();
    @(negedge clk) check_output("t4_ready_restored", {31'd0, bus.disp_ready}, 32'd1);
    next_cycle();

    // Flush with three entries waiting and a held result
    bus.cdb_gnt = 1'b0;
    apply_stimulus(ADDI_I, 2'd1, 1'b1, 2'd0, 32'd40, 1'b1, 32'd2);
    push_exp(2'd1, 32'd40, 32'd2, 1'b0);
    @(negedge clk);
    next_cycle(); idle();
    @(negedge clk) check_output("t6_issue", {31'd0, bus.alu_en}, 32'd1);
    next_cycle();
    flush = 1'b1;
    apply_stimulus(ADDI_I, 2'd0, 1'b1, 2'd0, 32'd60, 1'b1, 32'd0);
    @(negedge clk) check_output("t6_req_before_flush", {31'd0, bus.cdb_req}, 32'd1);
    check_output("t6_value_before_flush", bus.cdb_out_value, 32'd42);
    next_cycle(); flush = 1'b0; idle(); set_cdb(1'b1, 2'd0, 32'd9);
    @(negedge clk) check_output("t6_req_cleared", {31'd0, bus.cdb_req}, 32'd0);
    check_output("t6_disp_ready", {31'd0, bus.disp_ready}, 32'd1);
    check_output("t6_no_issue", {31'd0, bus.alu_en}, 32'd0);
    next_cycle(); idle();
    @(negedge clk) check_output("t6_flushed_no_wake", {31'd0, bus.alu_en}, 32'd0);
    next_cycle();

    // Unsupported opcode: freed with an illegal_op pulse and no broadcast
    bus.cdb_gnt = 1'b1;
    apply_stimulus(BAD_I, 2'd0, 1'b1, 2'd0, 32'd1, 1'b1, 32'd2);
    push_exp(2'd0, 32'd1, 32'd2, 1'b0);
    @(negedge clk);
    next_cycle(); idle();
    @(negedge clk) check_output("ill_issue", {31'd0, bus.alu_en}, 32'd1);
    check_output("ill_not_yet", {31'd0, bus.illegal_op}, 32'd0);
    next_cycle();
    @(negedge clk) check_output("ill_pulse", {31'd0, bus.illegal_op}, 32'd1);
    check_output("ill_no_cdb_req", {31'd0, bus.cdb_req}, 32'd0);
    next_cycle();
    @(negedge clk) check_output("ill_pulse_end", {31'd0, bus.illegal_op}, 32'd0);
    next_cycle();

    repeat (3) next_cycle();
    check_output("issue_queue_drained", 32'(iss_q.size()), 32'd0);
    check_output("cdb_queue_drained", 32'(cdb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
